// File: rtl/en_counter_pkg.sv
// Shared types and constants for the enable-gated counter core.
// The state encoding is fixed at 2 bits; the value 3 is unused and recovers to ST_INIT.
package en_counter_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/en_counter_core_if.sv
// Enable/count bundle between the wrapper and en_counter_core.
// The master drives en and reads q back; the counter core is the slave.
interface en_counter_core_if
    import en_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             en;
    logic [WIDTH-1:0] q;

    modport master (output en, input  q);
    modport slave  (input  en, output q);

endinterface

// File: rtl/en_counter_core.sv
// Enable-gated up-counter with one INIT cycle after reset and a registered output.
// Optional build macro: EN_COUNTER_SATURATE_EN makes the counter hold at all-ones instead of wrapping.
module en_counter_core
    import en_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    en_counter_core_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] counter_d;
    logic [WIDTH-1:0] q_q;

    // FIRST and RUN share the counting rule; any unused encoding falls back to INIT.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            ST_INIT: begin
                counter_d = '0;
                state_d   = ST_FIRST;
            end
            ST_FIRST, ST_RUN: begin
                if (bus.en) begin
`ifdef EN_COUNTER_SATURATE_EN
                    if (counter_q != {WIDTH{1'b1}}) begin
                        counter_d = counter_q + 1'b1;
                    end
`else
                    counter_d = counter_q + 1'b1;
`endif
                end
                state_d = ST_RUN;
            end
            default: begin
                counter_d = '0;
                state_d   = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            counter_q <= '0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            q_q       <= counter_d;
        end
    end

    assign bus.q = q_q;

endmodule

// File: tb/tb_en_counter_core.sv
// Directed bench for en_counter_core: a vector table for reset/enable sequencing,
// then hand-written sequences for async reset mid-count, wrap/saturate and illegal-state recovery.
module tb_en_counter_core;
    import en_counter_pkg::*;

    localparam int WIDTH = 8;
    localparam int NVEC  = 18;

    logic clk = 1'b0;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             resetN;
        logic             en;
        logic [WIDTH-1:0] expQ;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    en_counter_core_if #(.WIDTH(WIDTH)) busIf ();

    en_counter_core #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (busIf.slave)
    );

    // Inputs change on the falling edge so they are stable at the rising edge.
    task automatic applyStimulus(input logic r, input logic e);
        @(negedge clk);
        reset_n  = r;
        busIf.en = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expQ);
        checks++;
        if (busIf.q !== expQ) begin
            failures++;
            $display("[TB] FAIL %s: q=%0d expected=%0d", name, busIf.q, expQ);
        end
    endtask

    task automatic checkState(input string name, input state_t expS);
        checks++;
        if (dut.state_q !== expS) begin
            failures++;
            $display("[TB] FAIL %s: state=%0d expected=%0d", name, dut.state_q, expS);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        busIf.en = 1'b0;

        vecs[0]  = '{1'b0, 1'b1, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 8'd1};
        vecs[4]  = '{1'b1, 1'b1, 8'd2};
        vecs[5]  = '{1'b1, 1'b1, 8'd3};
        vecs[6]  = '{1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 8'd0};
        vecs[8]  = '{1'b1, 1'b0, 8'd0};
        vecs[9]  = '{1'b1, 1'b0, 8'd0};
        vecs[10] = '{1'b1, 1'b0, 8'd0};
        vecs[11] = '{1'b1, 1'b0, 8'd0};
        vecs[12] = '{1'b1, 1'b1, 8'd1};
        vecs[13] = '{1'b1, 1'b1, 8'd2};
        vecs[14] = '{1'b1, 1'b1, 8'd3};
        vecs[15] = '{1'b1, 1'b1, 8'd4};
        vecs[16] = '{1'b1, 1'b0, 8'd4};
        vecs[17] = '{1'b1, 1'b1, 8'd5};

        #2;
        checkOutput("resetAsync", 8'd0);
        checkState("resetState", ST_INIT);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].resetN, vecs[i].en);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].expQ);
        end

        // Count up to 200, then pull reset low between edges.
        for (int i = 0; i < 195; i++) begin
            applyStimulus(1'b1, 1'b1);
            tick();
        end
        checkOutput("countTo200", 8'd200);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("midCountReset", 8'd0);
        checkState("midCountResetState", ST_INIT);
        tick();
        checkOutput("resetHeld", 8'd0);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("initEdgeIgnoresEn", 8'd0);
        checkState("afterInitState", ST_FIRST);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("firstCountAfterReset", 8'd1);
        checkState("runState", ST_RUN);

        for (int i = 0; i < 253; i++) begin
            applyStimulus(1'b1, 1'b1);
            tick();
        end
        checkOutput("countTo254", 8'd254);
        begin
            logic [WIDTH-1:0] topExp [4];
`ifdef EN_COUNTER_SATURATE_EN
            topExp = '{8'd255, 8'd255, 8'd255, 8'd255};
`else
            topExp = '{8'd255, 8'd0, 8'd1, 8'd2};
`endif
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b1, 1'b1);
                tick();
                checkOutput($sformatf("topEdge%0d", i), topExp[i]);
            end
        end

        // Drive the unused state encoding and confirm recovery through INIT.
        @(negedge clk);
        reset_n  = 1'b1;
        busIf.en = 1'b1;
        force dut.state_q = state_t'(2'b11);
        #1;
        release dut.state_q;
        tick();
        checkOutput("illegalRecoverQ", 8'd0);
        checkState("illegalRecoverState", ST_INIT);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("postIllegalInit", 8'd0);
        checkState("postIllegalFirst", ST_FIRST);
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("postIllegalCount", 8'd1);
        checkState("postIllegalRun", ST_RUN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
